decoder_3_8_seq: RTL

- Sequential 3-to-8 decoder. It is the return path for the 8-to-3 priority encoder.
- Accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as a one-hot 8-bit word on d_out, holding it for a fixed number of cycles.
- Drives one-hot indicator banks and select lines from codes produced upstream by the encoder.

---
 rtl/decoder_3_8_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/decoder_3_8_seq.sv
// Sequential 3-to-8 decoder: buffers 3-bit codes in a small FIFO and replays each
// as a one-hot word on d_out for HOLD enabled cycles, back-to-back when codes are waiting.
module decoder_3_8_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       en,
    output logic [7:0] d_out,
    output logic       out_valid,
    output logic [7:0] dec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    d_out_q, d_out_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    dec_count_q, dec_count_d;

    logic full, empty, push, pop;

    // in_ready comes straight from the registered occupancy, so a pop in the
    // same cycle never opens a slot for a push while full.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // A load happens from IDLE, or from SHOW once the current word has used its hold.
    assign pop = en && !empty && (state_q == IDLE || hold_q == '0);

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no
        // path through the block leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        hold_d      = hold_q;
        d_out_d     = d_out_q;
        out_valid_d = out_valid_q;
        dec_count_d = dec_count_q;

        if (pop) begin
            d_out_d     = 8'd1 << mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            hold_d      = HW'(HOLD - 1);
            dec_count_d = dec_count_q + 8'd1;
            state_d     = SHOW;
        end else if (state_q == SHOW && en) begin
            if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else begin
                d_out_d     = 8'h00;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of the order of statements or processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            d_out_q     <= 8'h00;
            out_valid_q <= 1'b0;
            dec_count_q <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
            dec_count_q <= dec_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and occupancy define
    // which entries are live, so clearing the data itself would add nothing.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= d_in;
    end

    assign d_out     = d_out_q;
    assign out_valid = out_valid_q;
    assign dec_count = dec_count_q;

endmodule
